// File: rtl/mc_port_arbiter.sv
// Round-robin arbiter sharing one MC request/response port among NUM_REQ requesters.
// Requests pass through a one-deep output register; responses are steered back by the rtnctl tag.
module mc_port_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int RTNCTL_WIDTH = 32,
    parameter int OUT_W        = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_REQ-1:0]                     req_vld,
    input  logic [NUM_REQ*3-1:0]                   req_cmd,
    input  logic [NUM_REQ*4-1:0]                   req_scmd,
    input  logic [NUM_REQ*48-1:0]                  req_vadr,
    input  logic [NUM_REQ*2-1:0]                   req_size,
    input  logic [NUM_REQ*64-1:0]                  req_data,
    input  logic [NUM_REQ*(RTNCTL_WIDTH-ID_W)-1:0] req_rtnctl,
    output logic [NUM_REQ-1:0]                     req_gnt,
    output logic [NUM_REQ-1:0]                     rsp_vld,
    output logic [2:0]                             rsp_cmd,
    output logic [3:0]                             rsp_scmd,
    output logic [63:0]                            rsp_data,
    output logic [RTNCTL_WIDTH-ID_W-1:0]           rsp_rtnctl,
    input  logic [NUM_REQ-1:0]                     rsp_stall,
    output logic                                   mc_rq_vld,
    output logic [2:0]                             mc_rq_cmd,
    output logic [3:0]                             mc_rq_scmd,
    output logic [47:0]                            mc_rq_vadr,
    output logic [1:0]                             mc_rq_size,
    output logic [63:0]                            mc_rq_data,
    output logic [RTNCTL_WIDTH-1:0]                mc_rq_rtnctl,
    input  logic                                   mc_rq_stall,
    input  logic                                   mc_rs_vld,
    input  logic [2:0]                             mc_rs_cmd,
    input  logic [3:0]                             mc_rs_scmd,
    input  logic [63:0]                            mc_rs_data,
    input  logic [RTNCTL_WIDTH-1:0]                mc_rs_rtnctl,
    output logic                                   mc_rs_stall,
    output logic [NUM_REQ-1:0]                     outstanding_any,
    output logic                                   idle
);
    localparam int RW = RTNCTL_WIDTH - ID_W;

    // Handshakes: an MC request transfers when mc_rq_vld && !mc_rq_stall; req_gnt[i] means requester
    // i's fields are consumed this cycle; an MC response is accepted when mc_rs_vld && !mc_rs_stall.

    logic                    rq_vld_q, rq_vld_d;
    logic [2:0]              rq_cmd_q, rq_cmd_d;
    logic [3:0]              rq_scmd_q, rq_scmd_d;
    logic [47:0]             rq_vadr_q, rq_vadr_d;
    logic [1:0]              rq_size_q, rq_size_d;
    logic [63:0]             rq_data_q, rq_data_d;
    logic [RTNCTL_WIDTH-1:0] rq_rtnctl_q, rq_rtnctl_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [OUT_W-1:0]        cnt_q [NUM_REQ];
    logic [OUT_W-1:0]        cnt_d [NUM_REQ];

    logic                    load;
    logic [NUM_REQ-1:0]      elig;
    logic                    hi_found, lo_found, win_found;
    logic [ID_W-1:0]         hi_idx, lo_idx, win_idx;
    logic [2:0]              sel_cmd;
    logic [3:0]              sel_scmd;
    logic [47:0]             sel_vadr;
    logic [1:0]              sel_size;
    logic [63:0]             sel_data;
    logic [RW-1:0]           sel_rtnctl;

    logic [ID_W-1:0]         rs_id;
    logic                    rs_id_ok;
    logic                    rs_acc;
    logic                    dec_zero;

    assign load = rst_n && (!rq_vld_q || !mc_rq_stall);

    // Winner is the lowest eligible index at/after the pointer, else the lowest eligible overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            elig[i] = req_vld[i] && (cnt_q[i] != {OUT_W{1'b1}});
            if (elig[i]) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(i);
                if (ID_W'(i) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
        win_found = lo_found;
        win_idx   = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_cmd    = '0;
        sel_scmd   = '0;
        sel_vadr   = '0;
        sel_size   = '0;
        sel_data   = '0;
        sel_rtnctl = '0;
        req_gnt    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                sel_cmd    = req_cmd[i*3 +: 3];
                sel_scmd   = req_scmd[i*4 +: 4];
                sel_vadr   = req_vadr[i*48 +: 48];
                sel_size   = req_size[i*2 +: 2];
                sel_data   = req_data[i*64 +: 64];
                sel_rtnctl = req_rtnctl[i*RW +: RW];
                req_gnt[i] = load && win_found;
            end
        end
    end

    always_comb begin
        rq_vld_d    = rq_vld_q;
        rq_cmd_d    = rq_cmd_q;
        rq_scmd_d   = rq_scmd_q;
        rq_vadr_d   = rq_vadr_q;
        rq_size_d   = rq_size_q;
        rq_data_d   = rq_data_q;
        rq_rtnctl_d = rq_rtnctl_q;
        ptr_d       = ptr_q;
        if (load) begin
            rq_vld_d    = win_found;
            rq_cmd_d    = win_found ? sel_cmd : '0;
            rq_scmd_d   = win_found ? sel_scmd : '0;
            rq_vadr_d   = win_found ? sel_vadr : '0;
            rq_size_d   = win_found ? sel_size : '0;
            rq_data_d   = win_found ? sel_data : '0;
            rq_rtnctl_d = win_found ? {win_idx, sel_rtnctl} : '0;
            if (win_found) begin
                ptr_d = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
            end
        end
    end

    assign rs_id       = mc_rs_rtnctl[RTNCTL_WIDTH-1 -: ID_W];
    assign rs_id_ok    = ({1'b0, rs_id} < (ID_W + 1)'(NUM_REQ));
    assign mc_rs_stall = |rsp_stall;
    assign rs_acc      = mc_rs_vld && !mc_rs_stall;
    assign rsp_cmd     = mc_rs_cmd;
    assign rsp_scmd    = mc_rs_scmd;
    assign rsp_data    = mc_rs_data;
    assign rsp_rtnctl  = mc_rs_rtnctl[RW-1:0];

    // A grant and an accepted response on the same requester cancel out.
    always_comb begin
        dec_zero = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_vld[i] = mc_rs_vld && rs_id_ok && (rs_id == ID_W'(i));
            cnt_d[i]   = cnt_q[i];
            if (req_gnt[i] && !(rs_acc && rsp_vld[i])) begin
                cnt_d[i] = cnt_q[i] + OUT_W'(1);
            end else if (!req_gnt[i] && rs_acc && rsp_vld[i]) begin
                if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - OUT_W'(1);
            end
            if (rs_acc && rsp_vld[i] && (cnt_q[i] == '0)) dec_zero = 1'b1;
            outstanding_any[i] = (cnt_q[i] != '0);
        end
    end

    assign idle = !rq_vld_q && !(|outstanding_any);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq_vld_q    <= 1'b0;
            rq_cmd_q    <= '0;
            rq_scmd_q   <= '0;
            rq_vadr_q   <= '0;
            rq_size_q   <= '0;
            rq_data_q   <= '0;
            rq_rtnctl_q <= '0;
            ptr_q       <= '0;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            rq_vld_q    <= rq_vld_d;
            rq_cmd_q    <= rq_cmd_d;
            rq_scmd_q   <= rq_scmd_d;
            rq_vadr_q   <= rq_vadr_d;
            rq_size_q   <= rq_size_d;
            rq_data_q   <= rq_data_d;
            rq_rtnctl_q <= rq_rtnctl_d;
            ptr_q       <= ptr_d;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign mc_rq_vld    = rq_vld_q;
    assign mc_rq_cmd    = rq_cmd_q;
    assign mc_rq_scmd   = rq_scmd_q;
    assign mc_rq_vadr   = rq_vadr_q;
    assign mc_rq_size   = rq_size_q;
    assign mc_rq_data   = rq_data_q;
    assign mc_rq_rtnctl = rq_rtnctl_q;

    // Responses carrying an unknown tag, or for a requester with nothing outstanding, are errors.
    a_rs_id: assert property (@(posedge clk) disable iff (!rst_n) mc_rs_vld |-> rs_id_ok);
    a_cnt_underflow: assert property (@(posedge clk) disable iff (!rst_n) !dec_zero);

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Bench for mc_port_arbiter: reference model of grants/counters plus an expected-request queue.
module tb_mc_port_arbiter;
    localparam int NR    = 4;
    localparam int RW    = 30;
    localparam int EXP_W = 153;

    logic              clk, rst_n;
    logic [NR-1:0]     req_vld;
    logic [NR*3-1:0]   req_cmd;
    logic [NR*4-1:0]   req_scmd;
    logic [NR*48-1:0]  req_vadr;
    logic [NR*2-1:0]   req_size;
    logic [NR*64-1:0]  req_data;
    logic [NR*RW-1:0]  req_rtnctl;
    logic [NR-1:0]     req_gnt, rsp_vld, rsp_stall, outstanding_any;
    logic [2:0]        rsp_cmd, mc_rq_cmd, mc_rs_cmd;
    logic [3:0]        rsp_scmd, mc_rq_scmd, mc_rs_scmd;
    logic [63:0]       rsp_data, mc_rq_data, mc_rs_data;
    logic [RW-1:0]     rsp_rtnctl;
    logic              mc_rq_vld, mc_rq_stall, mc_rs_vld, mc_rs_stall, idle;
    logic [47:0]       mc_rq_vadr;
    logic [1:0]        mc_rq_size;
    logic [31:0]       mc_rq_rtnctl, mc_rs_rtnctl;

    mc_port_arbiter #(.NUM_REQ(4), .ID_W(2), .RTNCTL_WIDTH(32), .OUT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_cmd(req_cmd), .req_scmd(req_scmd), .req_vadr(req_vadr),
        .req_size(req_size), .req_data(req_data), .req_rtnctl(req_rtnctl), .req_gnt(req_gnt),
        .rsp_vld(rsp_vld), .rsp_cmd(rsp_cmd), .rsp_scmd(rsp_scmd), .rsp_data(rsp_data),
        .rsp_rtnctl(rsp_rtnctl), .rsp_stall(rsp_stall),
        .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
        .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_data(mc_rq_data),
        .mc_rq_rtnctl(mc_rq_rtnctl), .mc_rq_stall(mc_rq_stall),
        .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
        .mc_rs_data(mc_rs_data), .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_stall(mc_rs_stall),
        .outstanding_any(outstanding_any), .idle(idle)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_push   = 0;
    int n_xfer   = 0;
    logic resp_en = 1'b0;

    logic [EXP_W-1:0] exp_q[$];
    logic [31:0]      rs_q[$];

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic rand_fields();
        for (int i = 0; i < NR; i++) begin
            req_cmd[i*3 +: 3]    = 3'($urandom_range(0, 7));
            req_scmd[i*4 +: 4]   = 4'($urandom_range(0, 15));
            req_size[i*2 +: 2]   = 2'($urandom_range(0, 3));
            req_vadr[i*48 +: 48] = {16'($urandom), $urandom};
            req_data[i*64 +: 64] = {$urandom, $urandom};
            req_rtnctl[i*RW +: RW] = 30'($urandom);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (t < 64 && !(idle === 1'b1 && rs_q.size() == 0)) begin
            tick();
            t++;
        end
        tick();
        sample();
        check_eq("drain_idle", idle, 1'b1);
        tick();
    endtask

    // Responder: returns each transferred request's rtnctl as a response, one per cycle.
    always begin
        @(posedge clk);
        #1;
        if (resp_en) begin
            if (rs_q.size() != 0) begin
                mc_rs_vld    = 1'b1;
                mc_rs_rtnctl = rs_q.pop_front();
                mc_rs_cmd    = 3'($urandom_range(0, 7));
                mc_rs_scmd   = 4'($urandom_range(0, 15));
                mc_rs_data   = {$urandom, $urandom};
            end else begin
                mc_rs_vld = 1'b0;
            end
        end
    end

    // Scoreboard and reference model, evaluated away from the active edge.
    int               m_ptr, m_w, m_idx, m_id;
    int               m_cnt [NR];
    logic             m_rq_vld, m_load, m_found, m_acc, m_all0;
    logic [NR-1:0]    m_exp_gnt, m_exp_rsp, m_exp_oa;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_ptr    = 0;
            m_rq_vld = 1'b0;
            for (int i = 0; i < NR; i++) m_cnt[i] = 0;
            exp_q.delete();
            rs_q.delete();
        end else begin
            m_load  = !m_rq_vld || !mc_rq_stall;
            m_found = 1'b0;
            m_w     = 0;
            if (m_load) begin
                for (int k = 0; k < NR; k++) begin
                    m_idx = (m_ptr + k) % NR;
                    if (!m_found && req_vld[m_idx] && m_cnt[m_idx] < 3) begin
                        m_found = 1'b1;
                        m_w     = m_idx;
                    end
                end
            end
            m_exp_gnt = m_found ? 4'(1 << m_w) : 4'b0;
            check_eq("gnt", req_gnt, m_exp_gnt);
            check_eq("mc_rq_vld", mc_rq_vld, m_rq_vld);
            if (m_rq_vld) begin
                if (exp_q.size() == 0) begin
                    check_eq("exp_q_underflow", exp_q.size(), 1);
                end else begin
                    check_eq("mc_rq_fields",
                             {mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl},
                             exp_q[0]);
                    if (!mc_rq_stall) begin
                        void'(exp_q.pop_front());
                        rs_q.push_back(mc_rq_rtnctl);
                        n_xfer++;
                    end
                end
            end
            if (m_found) begin
                exp_q.push_back({req_cmd[m_w*3 +: 3], req_scmd[m_w*4 +: 4], req_size[m_w*2 +: 2],
                                 req_vadr[m_w*48 +: 48], req_data[m_w*64 +: 64],
                                 2'(m_w), req_rtnctl[m_w*RW +: RW]});
                n_push++;
            end
            m_id      = int'(mc_rs_rtnctl[31:30]);
            m_exp_rsp = mc_rs_vld ? 4'(1 << m_id) : 4'b0;
            check_eq("rsp_vld", rsp_vld, m_exp_rsp);
            check_eq("mc_rs_stall", mc_rs_stall, |rsp_stall);
            if (mc_rs_vld) begin
                check_eq("rsp_rtnctl", rsp_rtnctl, mc_rs_rtnctl[RW-1:0]);
                check_eq("rsp_data", {rsp_cmd, rsp_scmd, rsp_data}, {mc_rs_cmd, mc_rs_scmd, mc_rs_data});
            end
            m_all0 = 1'b1;
            for (int i = 0; i < NR; i++) begin
                m_exp_oa[i] = (m_cnt[i] != 0);
                if (m_cnt[i] != 0) m_all0 = 1'b0;
            end
            check_eq("outstanding_any", outstanding_any, m_exp_oa);
            check_eq("idle", idle, !m_rq_vld && m_all0);
            m_acc = mc_rs_vld && (rsp_stall == '0);
            if (m_found) m_cnt[m_w] = m_cnt[m_w] + 1;
            if (m_acc && m_cnt[m_id] > 0) m_cnt[m_id] = m_cnt[m_id] - 1;
            if (m_load) m_rq_vld = m_found;
            if (m_found) m_ptr = (m_w + 1) % NR;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int gcnt [NR];

    initial begin
        rst_n = 1'b0; req_vld = '0; rsp_stall = '0; mc_rq_stall = 1'b0;
        mc_rs_vld = 1'b0; mc_rs_cmd = '0; mc_rs_scmd = '0; mc_rs_data = '0; mc_rs_rtnctl = '0;
        rand_fields();
        repeat (3) @(posedge clk);
        #1;
        sample();
        check_eq("rst_mc_rq_vld", mc_rq_vld, 1'b0);
        check_eq("rst_mc_rq_fields", {mc_rq_vadr, mc_rq_rtnctl}, 80'h0);
        check_eq("rst_idle", idle, 1'b1);
        check_eq("rst_oa", outstanding_any, 4'b0);
        check_eq("rst_gnt", req_gnt, 4'b0);
        tick();
        rst_n = 1'b1;

        // Single requester
        rand_fields();
        req_vadr[2*48 +: 48]   = 48'h1000;
        req_rtnctl[2*RW +: RW] = 30'h5;
        req_vld = 4'b0100;
        sample();
        check_eq("single_gnt", req_gnt, 4'b0100);
        tick();
        req_vld = '0;
        sample();
        check_eq("single_vld", mc_rq_vld, 1'b1);
        check_eq("single_vadr", mc_rq_vadr, 48'h1000);
        check_eq("single_rtnctl", mc_rq_rtnctl, 32'h8000_0005);
        check_eq("single_oa2", outstanding_any[2], 1'b1);
        check_eq("single_idle", idle, 1'b0);
        tick();

        // Round-robin fairness over 100 grants
        resp_en = 1'b1;
        for (int i = 0; i < NR; i++) gcnt[i] = 0;
        for (int c = 0; c < 100; c++) begin
            rand_fields();
            req_vld = 4'b1111;
            sample();
            for (int i = 0; i < NR; i++) if (req_gnt[i]) gcnt[i]++;
            tick();
        end
        req_vld = '0;
        for (int i = 0; i < NR; i++) check_eq($sformatf("rr_count_%0d", i), gcnt[i], 25);
        drain();

        // MC request stall
        req_vld = 4'b1111;
        repeat (2) begin rand_fields(); sample(); tick(); end
        mc_rq_stall = 1'b1;
        repeat (5) begin
            rand_fields();
            sample();
            check_eq("stall_gnt", req_gnt, 4'b0);
            check_eq("stall_vld", mc_rq_vld, 1'b1);
            tick();
        end
        mc_rq_stall = 1'b0;
        rand_fields();
        sample();
        check_eq("stall_resume", |req_gnt, 1'b1);
        tick();
        repeat (3) begin rand_fields(); sample(); tick(); end
        req_vld = '0;
        drain();
        check_eq("no_loss_q", exp_q.size(), 0);
        check_eq("no_dup", n_xfer, n_push);

        // Response routing
        resp_en = 1'b0;
        req_vld = 4'b0010;
        sample();
        tick();
        req_vld = '0;
        sample();
        tick();
        rs_q.delete();
        mc_rs_vld = 1'b1; mc_rs_rtnctl = 32'h4000_0011; mc_rs_data = {$urandom, $urandom};
        rsp_stall = 4'b1000;
        sample();
        check_eq("route_stall", mc_rs_stall, 1'b1);
        check_eq("route_vld_stalled", rsp_vld, 4'b0010);
        tick();
        rsp_stall = '0;
        sample();
        check_eq("route_vld", rsp_vld, 4'b0010);
        check_eq("route_rtnctl", rsp_rtnctl, 30'h11);
        check_eq("route_oa1_held", outstanding_any[1], 1'b1);
        tick();
        mc_rs_vld = 1'b0;
        sample();
        check_eq("route_oa1_dec", outstanding_any[1], 1'b0);
        tick();

        // Counter saturation at 3 with OUT_W=2
        req_vld = 4'b0001;
        repeat (3) begin sample(); check_eq("sat_fill", req_gnt, 4'b0001); tick(); end
        sample();
        check_eq("sat_masked", req_gnt, 4'b0000);
        tick();
        req_vld = 4'b0101;
        sample();
        check_eq("sat_other", req_gnt, 4'b0100);
        tick();
        req_vld = 4'b0001;
        mc_rs_vld = 1'b1; mc_rs_rtnctl = {2'b00, 30'h3};
        sample();
        check_eq("sat_rsp_cycle", req_gnt, 4'b0000);
        tick();
        mc_rs_vld = 1'b0;
        sample();
        check_eq("sat_reenable", req_gnt, 4'b0001);
        tick();
        mc_rs_vld = 1'b1;
        sample();
        tick();
        sample();
        check_eq("same_cycle_gnt", req_gnt, 4'b0001);
        tick();
        mc_rs_vld = 1'b0;
        sample();
        check_eq("post_same_1", req_gnt, 4'b0001);
        tick();
        sample();
        check_eq("post_same_2", req_gnt, 4'b0000);
        tick();
        req_vld = '0;
        rs_q.delete();

        // Async reset mid-stream
        req_vld = 4'b1111;
        repeat (3) begin rand_fields(); sample(); tick(); end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_vld", mc_rq_vld, 1'b0);
        check_eq("arst_idle", idle, 1'b1);
        check_eq("arst_oa", outstanding_any, 4'b0);
        check_eq("arst_gnt", req_gnt, 4'b0);
        tick();
        rst_n = 1'b1;
        sample();
        check_eq("arst_first_gnt", req_gnt, 4'b0001);
        tick();
        req_vld = '0;
        repeat (3) begin sample(); tick(); end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_port_arbiter.md
Name: mc_port_arbiter

Overview:
- Shares one MC request/response port among NUM_REQ requesters, e.g. PDES event cores inside phold.
- Arbitrates requests round-robin and drives them through a one-deep output register.
- Tags the upper rtnctl bits with the requester index.
- Steers MC responses back by that tag and tracks outstanding requests per requester for drain/idle detection.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, tag width (ID_W >= log2 NUM_REQ).
- RTNCTL_WIDTH, 32, MC rtnctl width.
- OUT_W, 8, width of each per-requester outstanding counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  NUM_REQ  request valid, one bit per requester
- req_cmd  in  NUM_REQ*3  MC cmd, packed
- req_scmd  in  NUM_REQ*4  MC scmd
- req_vadr  in  NUM_REQ*48  virtual address
- req_size  in  NUM_REQ*2  size
- req_data  in  NUM_REQ*64  write data
- req_rtnctl  in  NUM_REQ*(RTNCTL_WIDTH-ID_W)  requester-private rtnctl
- req_gnt  out  NUM_REQ  one-hot grant; the request is consumed this cycle
- rsp_vld  out  NUM_REQ  one-hot response valid
- rsp_cmd  out  3  broadcast response cmd
- rsp_scmd  out  4  broadcast response scmd
- rsp_data  out  64  broadcast response data
- rsp_rtnctl  out  RTNCTL_WIDTH-ID_W  rtnctl with tag stripped
- rsp_stall  in  NUM_REQ  per-requester response backpressure
- mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size, mc_rq_data, mc_rq_rtnctl  out  1/3/4/48/2/64/RTNCTL_WIDTH  MC request
- mc_rq_stall  in  1  MC request backpressure
- mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl  in  1/3/4/64/RTNCTL_WIDTH  MC response
- mc_rs_stall  out  1  response backpressure to MC
- outstanding_any  out  NUM_REQ  counter i nonzero
- idle  out  1  no buffered request and all counters zero

Behaviour:
- Reset (rst_n=0, async): output register empty (mc_rq_vld=0, all mc_rq_* fields 0), RR pointer=0, all counters 0. Consequently req_gnt=0, idle=1, outstanding_any=0. Requests in flight at reset are dropped and their responses are not tracked.
- MC request transfer: a cycle with mc_rq_vld=1 and mc_rq_stall=0.
- load = !mc_rq_vld || !mc_rq_stall.
- Eligible requester i: req_vld[i]=1 and counter[i] != all-ones. A full counter masks the requester.
- Arbitration, when load=1 and any requester is eligible:
  - Winner w = first eligible index at or after the pointer, wrapping modulo NUM_REQ.
  - req_gnt = one-hot(w), combinational, same cycle.
  - Output register captures w's fields; mc_rq_rtnctl = {w[ID_W-1:0], req_rtnctl_w}.
  - Pointer <= (w+1) mod NUM_REQ.
- When load=1 and nothing is eligible: register clears (mc_rq_vld=0 next cycle); pointer holds.
- When load=0: register and pointer hold; req_gnt=0.
- Request latency: grant in cycle N, mc_rq_vld in cycle N+1. Sustained throughput is 1 request/cycle while the MC does not stall.
- Response steering, combinational:
  - id = mc_rs_rtnctl[RTNCTL_WIDTH-1 -: ID_W].
  - rsp_vld[i] = mc_rs_vld && id==i.
  - rsp_cmd, rsp_scmd, rsp_data and rsp_rtnctl (low bits of mc_rs_rtnctl) are broadcast.
  - mc_rs_stall = |rsp_stall.
  - Response accepted = mc_rs_vld && !mc_rs_stall.
- id >= NUM_REQ: no rsp_vld asserted, no counter change; assertion fires in simulation.
- Counters: counter[w] +1 on grant; counter[id] -1 on response accept. Both on the same requester in the same cycle: net unchanged.
- Decrement of a zero counter: saturates at 0; assertion fires.
- idle = !mc_rq_vld && all counters zero.

Test Plan:
- Single requester: req_vld[2]=1 for one cycle with vadr=0x1000, rtnctl=0x5. Required: req_gnt=4'b0100 the same cycle; next cycle mc_rq_vld=1, vadr=0x1000, rtnctl=0x80000005; outstanding_any[2]=1, idle=0.
- Round-robin fairness: all four requesters valid continuously, no stall. Required: grants 0,1,2,3,0,... one per cycle; each requester receives 25 of 100 grants.
- Stall: mc_rq_stall=1 for 5 cycles while requests pend. Required: mc_rq_* held stable, req_gnt=0 throughout; grants resume the cycle the stall drops; no request lost or duplicated.
- Response routing: mc_rs_vld with rtnctl=0x40000011 and rsp_stall=0. Required: rsp_vld=4'b0010, rsp_rtnctl=0x00000011, counter[1] decrements.
  - Same response with rsp_stall[3]=1: mc_rs_stall=1 and counter[1] unchanged.
- Counter saturation (OUT_W=2): 3 grants to requester 0 with no responses. Required: requester 0 masked and others granted; one response for requester 0 re-enables it.
  - Grant and response to requester 0 in the same cycle: count unchanged.
- Async reset mid-stream with mc_rq_vld=1. Required: mc_rq_vld=0 immediately on rst_n fall; idle=1; after release, the first grant goes to requester 0.
